// File: rtl/fp_addsub_param.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_param
// Purpose  : Parametrised floating-point adder/subtractor with a fixed five-step
//            FSM, round-to-nearest-even, flush-to-zero and status flags.
// Revision : 1.0
// ============================================================================
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   load,
    input  logic                   PlusOrMinus,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    output logic [EXP_W+MAN_W:0]   sumFinal,
    output logic                   ready,
    output logic                   done,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MX  = MAN_W + 4;
    localparam int LZW = $clog2(MX + 1);

    localparam logic [EXP_W-1:0] c_EXP_MAX = '1;
    localparam logic [W-1:0]     c_QNAN    = {1'b0, c_EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ALIGN = 3'd1;
    localparam logic [2:0] c_S_ADD   = 3'd2;
    localparam logic [2:0] c_S_NORM  = 3'd3;
    localparam logic [2:0] c_S_ROUND = 3'd4;
    localparam logic [2:0] c_S_DONE  = 3'd5;

    logic [2:0]       r_state;
    logic [W-1:0]     r_a, r_b;
    logic             r_sx, r_sub, r_zsign, r_special, r_spec_inv;
    logic [W-1:0]     r_spec_val;
    logic [EXP_W-1:0] r_ex;
    logic [MX-1:0]    r_mx, r_my;
    logic [MX:0]      r_sum;
    logic [MX-1:0]    r_nman;
    logic [EXP_W:0]   r_nexp;
    logic             r_nzero, r_ntiny;

    logic w_accept;
    assign ready    = (r_state == c_S_IDLE) || (r_state == c_S_DONE);
    assign done     = (r_state == c_S_DONE);
    assign w_accept = en & load & ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else if (en) begin
            case (r_state)
                c_S_IDLE:  r_state <= load ? c_S_ALIGN : c_S_IDLE;
                c_S_ALIGN: r_state <= c_S_ADD;
                c_S_ADD:   r_state <= c_S_NORM;
                c_S_NORM:  r_state <= c_S_ROUND;
                c_S_ROUND: r_state <= c_S_DONE;
                c_S_DONE:  r_state <= load ? c_S_ALIGN : c_S_IDLE;
                default:   r_state <= c_S_IDLE;
            endcase
        end
    end

    // ---------------- ALIGN: classify, order by magnitude, shift Y ----------
    logic [EXP_W-1:0] w_ea, w_eb, w_ex, w_ey, w_shamt;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_inv, w_swap;
    logic [W-2:0]     w_key_a, w_key_b;
    logic [W-1:0]     w_x, w_y, w_spec_val;
    logic [MX-1:0]    w_mx, w_my, w_my_sh, w_lost;

    assign w_ea    = r_a[W-2:MAN_W];
    assign w_eb    = r_b[W-2:MAN_W];
    assign w_a_nan = (w_ea == c_EXP_MAX) && (r_a[MAN_W-1:0] != '0);
    assign w_b_nan = (w_eb == c_EXP_MAX) && (r_b[MAN_W-1:0] != '0);
    assign w_a_inf = (w_ea == c_EXP_MAX) && (r_a[MAN_W-1:0] == '0);
    assign w_b_inf = (w_eb == c_EXP_MAX) && (r_b[MAN_W-1:0] == '0);
    assign w_inv   = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (r_a[W-1] ^ r_b[W-1]));
    assign w_spec_val = w_inv   ? c_QNAN :
                        w_a_inf ? {r_a[W-1], c_EXP_MAX, {MAN_W{1'b0}}} :
                                  {r_b[W-1], c_EXP_MAX, {MAN_W{1'b0}}};

    // Denormal inputs count as zero, so their fraction must not enter the compare.
    assign w_key_a = (w_ea == '0) ? '0 : r_a[W-2:0];
    assign w_key_b = (w_eb == '0) ? '0 : r_b[W-2:0];
    assign w_swap  = w_key_b > w_key_a;
    assign w_x     = w_swap ? r_b : r_a;
    assign w_y     = w_swap ? r_a : r_b;
    assign w_ex    = w_x[W-2:MAN_W];
    assign w_ey    = w_y[W-2:MAN_W];
    assign w_shamt = w_ex - w_ey;
    assign w_mx    = (w_ex == '0) ? '0 : {1'b1, w_x[MAN_W-1:0], 3'b000};
    assign w_my    = (w_ey == '0) ? '0 : {1'b1, w_y[MAN_W-1:0], 3'b000};
    assign w_my_sh = w_my >> w_shamt;
    assign w_lost  = w_my & ~({MX{1'b1}} << w_shamt);

    // ---------------- NORM: leading-zero count and exponent adjust ----------
    function automatic logic [LZW-1:0] f_lzc(input logic [MX-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(MX);
        for (int i = 0; i < MX; i++) begin
            if (v[i]) n = LZW'(MX - 1 - i);
        end
        return n;
    endfunction

    logic [LZW-1:0]   w_lz;
    logic [EXP_W+1:0] w_nexp_sub;
    logic [MX-1:0]    w_nman;
    logic [EXP_W:0]   w_nexp;
    logic             w_ntiny;

    assign w_lz       = f_lzc(r_sum[MX-1:0]);
    assign w_nexp_sub = {2'b00, r_ex} - (EXP_W+2)'(w_lz);

    always_comb begin
        w_nman  = r_sum[MX-1:0] << w_lz;
        w_nexp  = w_nexp_sub[EXP_W:0];
        w_ntiny = w_nexp_sub[EXP_W+1] | (w_nexp_sub == '0);
        if (r_sum[MX]) begin
            w_nman  = {r_sum[MX:2], r_sum[1] | r_sum[0]};
            w_nexp  = {1'b0, r_ex} + 1'b1;
            w_ntiny = 1'b0;
        end
    end

    // ---------------- ROUND: nearest-even on guard/round/sticky -------------
    logic             w_inc, w_ovf;
    logic [MAN_W+1:0] w_rman;
    logic [EXP_W:0]   w_rexp;
    logic [MAN_W-1:0] w_rfrac;

    assign w_inc   = r_nman[2] & (r_nman[1] | r_nman[0] | r_nman[3]);
    assign w_rman  = {1'b0, r_nman[MX-1:3]} + (MAN_W+2)'(w_inc);
    assign w_rexp  = r_nexp + (EXP_W+1)'(w_rman[MAN_W+1]);
    assign w_rfrac = w_rman[MAN_W+1] ? w_rman[MAN_W:1] : w_rman[MAN_W-1:0];
    assign w_ovf   = w_rexp >= {1'b0, c_EXP_MAX};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sx       <= 1'b0;
            r_sub      <= 1'b0;
            r_zsign    <= 1'b0;
            r_special  <= 1'b0;
            r_spec_inv <= 1'b0;
            r_spec_val <= '0;
            r_ex       <= '0;
            r_mx       <= '0;
            r_my       <= '0;
            r_sum      <= '0;
            r_nman     <= '0;
            r_nexp     <= '0;
            r_nzero    <= 1'b0;
            r_ntiny    <= 1'b0;
            sumFinal   <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            invalid    <= 1'b0;
        end else if (w_accept) begin
            r_a       <= A;
            r_b       <= {B[W-1] ^ PlusOrMinus, B[W-2:0]};
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (en) begin
            case (r_state)
                c_S_ALIGN: begin
                    r_sx       <= w_x[W-1];
                    r_sub      <= w_x[W-1] ^ w_y[W-1];
                    r_zsign    <= w_x[W-1] & w_y[W-1];
                    r_special  <= w_inv | w_a_inf | w_b_inf;
                    r_spec_inv <= w_inv;
                    r_spec_val <= w_spec_val;
                    r_ex       <= w_ex;
                    r_mx       <= w_mx;
                    r_my       <= {w_my_sh[MX-1:1], w_my_sh[0] | (|w_lost)};
                end
                c_S_ADD: begin
                    r_sum <= r_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                                   : ({1'b0, r_mx} + {1'b0, r_my});
                end
                c_S_NORM: begin
                    r_nman  <= w_nman;
                    r_nexp  <= w_nexp;
                    r_nzero <= (r_sum == '0);
                    r_ntiny <= w_ntiny;
                end
                c_S_ROUND: begin
                    if (r_special) begin
                        sumFinal <= r_spec_val;
                        invalid  <= r_spec_inv;
                    end else if (r_nzero) begin
                        sumFinal <= {r_zsign, {(W-1){1'b0}}};
                    end else if (r_ntiny) begin
                        sumFinal  <= {r_sx, {(W-1){1'b0}}};
                        underflow <= 1'b1;
                    end else if (w_ovf) begin
                        sumFinal <= {r_sx, c_EXP_MAX, {MAN_W{1'b0}}};
                        overflow <= 1'b1;
                    end else begin
                        sumFinal <= {r_sx, w_rexp[EXP_W-1:0], w_rfrac};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_param
// Purpose  : Directed and random checks of fp_addsub_param against an exact
//            wide-integer arithmetic model with nearest-even rounding.
// Revision : 1.0
// ============================================================================
module tb_fp_addsub_param;
    logic        clk, rst, en, load, PlusOrMinus;
    logic [31:0] A, B, sumFinal;
    logic        ready, done, overflow, underflow, invalid;
    int          errors = 0;
    int          checks = 0;

    fp_addsub_param #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .PlusOrMinus(PlusOrMinus),
        .A(A), .B(B), .sumFinal(sumFinal), .ready(ready), .done(done),
        .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact value = integer mantissa scaled by 2^(exp-1); sum exactly, then round once.
    function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic pom);
        logic [31:0]  bb;
        logic         sa, sb, s;
        int           ea, eb, p, e, sh;
        logic [299:0] ma, mb, mag, keep, rem, half;
        bb = {b[31] ^ pom, b[30:0]};
        sa = a[31];
        sb = bb[31];
        ea = int'(a[30:23]);
        eb = int'(bb[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && bb[22:0] != 0) ||
            (ea == 255 && eb == 255 && sa != sb))
            return {3'b001, 32'h7FC00000};
        if (ea == 255) return {3'b000, sa, 8'hFF, 23'h0};
        if (eb == 255) return {3'b000, sb, 8'hFF, 23'h0};
        ma = '0;
        mb = '0;
        if (ea != 0) ma = {276'b0, 1'b1, a[22:0]} << (ea - 1);
        if (eb != 0) mb = {276'b0, 1'b1, bb[22:0]} << (eb - 1);
        if (sa == sb) begin
            mag = ma + mb; s = sa;
        end else if (ma >= mb) begin
            mag = ma - mb; s = sa;
        end else begin
            mag = mb - ma; s = sb;
        end
        if (mag == 0) return {3'b000, sa & sb, 31'h0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) return {3'b010, s, 31'h0};
        sh   = p - 23;
        keep = mag >> sh;
        if (sh > 0) begin
            rem  = mag - (keep << sh);
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
            if (keep[24]) begin
                keep = keep >> 1;
                e    = e + 1;
            end
        end
        if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
        return {3'b000, s, 8'(e), keep[22:0]};
    endfunction

    // Starts an op (from IDLE or DONE) and leaves time just after the done edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic p, input logic [34:0] exp);
        int n;
        A = a; B = b; PlusOrMinus = p; load = 1'b1;
        step();
        load = 1'b0; A = $urandom; B = $urandom; PlusOrMinus = ~p;
        chk({tag, "_busy"}, {63'b0, ready}, 64'd0);
        n = 1;
        while (!done && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd5);
        chk({tag, "_res"}, {29'b0, sumFinal, overflow, underflow, invalid},
            {29'b0, exp[31:0], exp[34:32]});
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rp;
        int          n, t;
        rst = 1'b0; en = 1'b1; load = 1'b0; PlusOrMinus = 1'b0;
        A = 32'h40D80000; B = 32'h40400000;
        step();
        step();
        chk("reset", {27'b0, ready, done, sumFinal, overflow, underflow, invalid},
            {27'b0, 1'b1, 1'b0, 32'h0, 3'b000});
        rst = 1'b1;
        step();

        run_op("add975", 32'h40D80000, 32'h40400000, 1'b0, {3'b000, 32'h411C0000});
        step();
        chk("done_pulse", {62'b0, done, ready}, {62'b0, 1'b0, 1'b1});
        run_op("sub375", 32'h40D80000, 32'h40400000, 1'b1, {3'b000, 32'h40700000});
        run_op("negadd", 32'hC0D80000, 32'h40400000, 1'b0, {3'b000, 32'hC0700000});
        run_op("xminx",  32'hC0D80000, 32'hC0D80000, 1'b1, {3'b000, 32'h00000000});
        run_op("tieeven", 32'h3F800000, 32'h33800000, 1'b0, {3'b000, 32'h3F800000});
        run_op("tieup",  32'h3F800000, 32'h33800001, 1'b0, {3'b000, 32'h3F800001});
        run_op("ovf",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {3'b100, 32'h7F800000});
        run_op("infinf", 32'h7F800000, 32'h7F800000, 1'b1, {3'b001, 32'h7FC00000});
        run_op("nzero",  32'h80000000, 32'h80000000, 1'b0, {3'b000, 32'h80000000});
        run_op("pzero",  32'h00000000, 32'h80000000, 1'b0, {3'b000, 32'h00000000});
        run_op("infpf",  32'h7F800000, 32'h3F800000, 1'b1, {3'b000, 32'h7F800000});
        run_op("undf",   32'h00800000, 32'h00800001, 1'b1, {3'b010, 32'h80000000});
        run_op("nanin",  32'h7FC12345, 32'h3F800000, 1'b0, {3'b001, 32'h7FC00000});

        // Stall: load in ALIGN is ignored, then en low for three edges.
        A = 32'h40D80000; B = 32'h40400000; PlusOrMinus = 1'b0; load = 1'b1;
        step();
        A = 32'h3F800000; B = 32'h3F800000;
        step();
        load = 1'b0; en = 1'b0;
        step(); step(); step();
        chk("stall_busy", {62'b0, ready, done}, 64'd0);
        en = 1'b1;
        n = 5;
        while (!done && n < 14) begin
            step();
            n++;
        end
        chk("stall_lat", 64'(n), 64'd8);
        chk("stall_res", {32'b0, sumFinal}, {32'b0, 32'h411C0000});
        en = 1'b0;
        step();
        chk("en_hold_done", {63'b0, done}, 64'd1);
        en = 1'b1;
        step();
        chk("idle_after", {62'b0, done, ready}, {62'b0, 1'b0, 1'b1});

        // Asynchronous reset while in NORM.
        A = 32'h3F800000; B = 32'h40000000; load = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("async_rst", {27'b0, ready, done, sumFinal, overflow, underflow, invalid},
            {27'b0, 1'b1, 1'b0, 32'h0, 3'b000});
        step();
        rst = 1'b1;
        step();
        run_op("post_rst", 32'h3F800000, 32'h40000000, 1'b0, {3'b000, 32'h40400000});

        for (int k = 0; k < 60; k++) begin
            ra = $urandom;
            t  = int'($urandom_range(1, 254));
            ra[30:23] = 8'(t);
            rb = $urandom;
            rp = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1: rb = {1'($urandom_range(0, 1)), ra[30:0] ^ {23'b0, 8'($urandom_range(0, 255))}};
                2: rb[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                3: ra[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                default: begin
                    t = t + int'($urandom_range(0, 60)) - 30;
                    if (t < 1) t = 1;
                    if (t > 254) t = 254;
                    rb[30:23] = 8'(t);
                end
            endcase
            if ($urandom_range(0, 3) == 0) step();
            run_op("rand", ra, rb, rp, ref_model(ra, rb, rp));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
